alu_iter_exec: RTL
==================

// Module: alu_iter_exec
// PURPOSE
//  EX-stage execution unit that consumes the 4-bit alu_op produced by the ALU-control decoder.
//  Executes it on two XLEN operands under a valid/ready handshake.
//  Add/sub/compare/logic/pass-B ops complete one cycle after accept.
//  Shifts are done iteratively, SHIFT_STEP bits per cycle (area-reduced core); ready_o low stalls ID/EX.
// PARAMETERS
//  XLEN        32  operand/result width
//  SHIFT_STEP  1   max bits shifted per cycle; power of two, 1..XLEN/2
// PORTS
//  clk_i        in   1     clock; all state changes on rising edge
//  rst_i        in   1     synchronous reset, active-high
//  flush_i      in   1     abort in-flight op (branch mispredict / trap)
//  valid_i      in   1     operands + alu_op_i valid this cycle
//  ready_o      out  1     unit can accept this cycle
//  alu_op_i     in   4     0 add,1 sub,2 slt,3 sltu,4 xor,5 or,6 and,7 sll,8 srl,9 sra,A pass B
//  operand_a_i  in   XLEN  rs1 / PC operand
//  operand_b_i  in   XLEN  rs2 / imm operand; shamt = operand_b_i[$clog2(XLEN)-1:0]
//  result_o     out  XLEN  result; held until next completion
//  valid_o      out  1     result_o valid; one-cycle pulse per completed op
//  busy_o       out  1     iterative shift in progress
// BEHAVIOUR
//  Reset (rst_i=1 at edge): state IDLE, result_o=0, valid_o=0; ready_o=1, busy_o=0 in the cycle after.
//  Accept = valid_i & ready_o & ~flush_i. ready_o = (state!=SHIFT). busy_o = (state==SHIFT).
//  States:
//   IDLE: on accept, non-shift op or shamt==0 -> DONE, result registered.
//         Shift with shamt>0 -> SHIFT; latch operand A, op and remaining=shamt.
//   SHIFT: each cycle shift the latched value by k=min(SHIFT_STEP, remaining); remaining -= k.
//          remaining hits 0 -> DONE with final value in result_o. Input ignored (ready_o=0).
//   DONE: valid_o=1 for exactly this cycle. On accept, apply the IDLE rules (back-to-back ops).
//         Otherwise -> IDLE.
//  Latency: accept at cycle N -> valid_o at N+1 for non-shift or shamt 0.
//   Shift: valid_o at N+1+ceil(shamt/SHIFT_STEP).
//  Arithmetic: add/sub modulo 2^XLEN, no flags.
//   slt signed, sltu unsigned; result 1 or 0, zero-extended.
//   sll/srl fill 0; sra fills sign bit of operand_a_i captured at accept. Pass-B: result=operand_b_i.
//   Op codes B..F: result 0, 1-cycle latency, no error.
//  flush_i: highest priority after reset; next state IDLE, valid_o=0 next cycle.
//   Same-cycle valid_i is dropped; result_o keeps last completed value.
//  rst_i mid-shift: abandons op, all outputs to reset values; no valid_o for it.
//  valid_o never asserts without a matching accept; one valid_o per accepted, unflushed op.
// TESTING
//  1 add A=0x7FFFFFFF B=1 -> valid_o at N+1, result 0x80000000; sub 0,1 -> 0xFFFFFFFF.
//  2 slt A=0xFFFFFFFF B=1 -> 1; sltu same operands -> 0; pass B=0xDEADBEEF -> 0xDEADBEEF.
//  3 SHIFT_STEP=1: sra A=0x80000000 shamt 31 -> ready_o low 31 cycles, valid_o at N+32, result 0xFFFFFFFF.
//    Then sll shamt 0 -> N+1.
//  4 SHIFT_STEP=4: srl A=0xF0000000 shamt 7 -> valid_o at N+3, result 0x01E00000.
//    Back-to-back add accepted in DONE cycle -> next valid_o one cycle later.
//  5 flush_i 3 cycles into a sll shamt 20 -> no valid_o, ready_o=1 next cycle.
//    result_o unchanged; a valid_i with flush_i is dropped.
//  6 rst_i mid-shift -> result_o=0, valid_o=0, busy_o=0, ready_o=1.
//    Random ops vs reference model: one valid_o per accept.

Source files
------------

// File: rtl/alu_iter_exec.sv
// EX-stage ALU: single-cycle add/sub/compare/logic/pass-B, iterative shifter.
// Latency: 1 cycle after accept; shifts 1 + ceil(shamt/SHIFT_STEP) cycles.
// Backpressure: ready_o drops while a shift iterates; flush_i aborts any op.
module alu_iter_exec #(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [3:0]      alu_op_i,
  input  logic [XLEN-1:0] operand_a_i,
  input  logic [XLEN-1:0] operand_b_i,
  output logic [XLEN-1:0] result_o,
  output logic            valid_o,
  output logic            busy_o
);

  localparam int            SW   = $clog2(XLEN);
  localparam logic [SW-1:0] STEP = SW'(SHIFT_STEP);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] sh_val_q;
  logic [XLEN-1:0] result_q;
  logic [XLEN-1:0] op_res;
  logic [XLEN-1:0] sh_next;
  logic [XLEN-1:0] res_d;
  logic [3:0]      sh_op_q;
  logic [SW-1:0]   rem_q;
  logic [SW-1:0]   shamt;
  logic [SW-1:0]   step_k;
  logic            accept;
  logic            is_shift;
  logic            load_res;
  logic            load_sh;

  assign ready_o  = (state_q != SHIFT);
  assign busy_o   = (state_q == SHIFT);
  assign valid_o  = (state_q == DONE);
  assign result_o = result_q;

  assign accept   = valid_i & ready_o & ~flush_i;
  assign shamt    = operand_b_i[SW-1:0];
  assign is_shift = (alu_op_i == 4'h7) || (alu_op_i == 4'h8) || (alu_op_i == 4'h9);
  // Last iteration may shift fewer than SHIFT_STEP bits.
  assign step_k   = (rem_q < STEP) ? rem_q : STEP;

  // Single-cycle result; shifts land here only when shamt is zero.
  always_comb begin
    op_res = '0;
    case (alu_op_i)
      4'h0: op_res = operand_a_i + operand_b_i;
      4'h1: op_res = operand_a_i - operand_b_i;
      4'h2: op_res = {{(XLEN-1){1'b0}}, ($signed(operand_a_i) < $signed(operand_b_i))};
      4'h3: op_res = {{(XLEN-1){1'b0}}, (operand_a_i < operand_b_i)};
      4'h4: op_res = operand_a_i ^ operand_b_i;
      4'h5: op_res = operand_a_i | operand_b_i;
      4'h6: op_res = operand_a_i & operand_b_i;
      4'h7, 4'h8, 4'h9: op_res = operand_a_i;
      4'hA: op_res = operand_b_i;
      default: op_res = '0;
    endcase
  end

  // One shifter iteration on the latched value; sra keeps the captured sign bit.
  always_comb begin
    sh_next = sh_val_q;
    case (sh_op_q)
      4'h7: sh_next = sh_val_q << step_k;
      4'h8: sh_next = sh_val_q >> step_k;
      4'h9: sh_next = $signed(sh_val_q) >>> step_k;
      default: sh_next = sh_val_q;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state and datapath load enables; flush overrides everything.
  always_comb begin
    state_d  = state_q;
    load_res = 1'b0;
    load_sh  = 1'b0;
    res_d    = op_res;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (accept) begin
          if (is_shift && (shamt != '0)) begin
            state_d = SHIFT;
            load_sh = 1'b1;
          end else begin
            state_d  = DONE;
            load_res = 1'b1;
          end
        end
      end
      SHIFT: begin
        if (rem_q == step_k) begin
          state_d  = DONE;
          load_res = 1'b1;
          res_d    = sh_next;
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush_i) begin
      state_d  = IDLE;
      load_res = 1'b0;
      load_sh  = 1'b0;
    end
  end

  // Result holds until the next completion; shifter state advances while iterating.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      result_q <= '0;
      sh_val_q <= '0;
      sh_op_q  <= 4'h0;
      rem_q    <= '0;
    end else begin
      if (load_res) result_q <= res_d;
      if (load_sh) begin
        sh_val_q <= operand_a_i;
        sh_op_q  <= alu_op_i;
        rem_q    <= shamt;
      end else if (state_q == SHIFT) begin
        sh_val_q <= sh_next;
        rem_q    <= rem_q - step_k;
      end
    end
  end

endmodule
